// File: rtl/store_lane_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module  : store_lane_buffer_if
//  Brief   : Store request channel and data-memory write channel bundle.
//  Revision: 1.0
// ============================================================================
interface store_lane_buffer_if #(
    parameter int AW    = 32,
    parameter int DEPTH = 2
);
    logic                   st_valid;
    logic                   st_ready;
    logic [AW-1:0]          st_addr;
    logic [31:0]            st_data;
    logic [1:0]             st_size;
    logic                   st_misalign;
    logic [AW-1:0]          st_bad_addr;
    logic                   mem_wvalid;
    logic                   mem_wready;
    logic [AW-1:0]          mem_waddr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_wbe;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_wready,
        input  st_ready, st_misalign, st_bad_addr, mem_wvalid, mem_waddr,
               mem_wdata, mem_wbe, count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_wready,
        output st_ready, st_misalign, st_bad_addr, mem_wvalid, mem_waddr,
               mem_wdata, mem_wbe, count, empty
    );
endinterface
`default_nettype wire

// File: rtl/store_lane_buffer.sv
`default_nettype none
// ============================================================================
//  Module  : store_lane_buffer
//  Brief   : Places SB/SH/SW data on byte lanes, buffers it and drains it to
//            data memory; rejects misaligned or illegal-size stores.
//  Revision: 1.0
// ============================================================================
module store_lane_buffer #(
    parameter int AW    = 32,
    parameter int DEPTH = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    store_lane_buffer_if.slave bus
);
    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [AW-1:0]      r_addr [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [3:0]         r_be   [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_misalign;
    logic [AW-1:0]      r_bad_addr;

    logic               w_ready;
    logic               w_valid;
    logic               w_accept;
    logic               w_legal;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_data;
    logic [3:0]         w_be;

    // Ready and valid come from registered occupancy only, so neither side
    // sees a combinational path from the other.
    assign w_ready  = (r_count < c_FULL);
    assign w_valid  = (r_count != '0);
    assign w_accept = bus.st_valid & w_ready;
    assign w_push   = w_accept & w_legal;
    assign w_pop    = w_valid & bus.mem_wready;

    always_comb begin
        w_legal = 1'b0;
        w_data  = 32'h0;
        w_be    = 4'b0000;
        case (bus.st_size)
            2'b00: begin
                w_legal = 1'b1;
                w_data  = {4{bus.st_data[7:0]}};
                w_be    = 4'b0001 << bus.st_addr[1:0];
            end
            2'b01: begin
                w_legal = ~bus.st_addr[0];
                w_data  = {2{bus.st_data[15:0]}};
                w_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_legal = (bus.st_addr[1:0] == 2'b00);
                w_data  = bus.st_data;
                w_be    = 4'b1111;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
            r_bad_addr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_misalign <= w_accept & ~w_legal;
            if (w_accept & ~w_legal) begin
                r_bad_addr <= bus.st_addr;
            end
        end
    end

    // Entry storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= {bus.st_addr[AW-1:2], 2'b00};
            r_data[r_wr_ptr] <= w_data;
            r_be[r_wr_ptr]   <= w_be;
        end
    end

    assign bus.st_ready    = w_ready;
    assign bus.st_misalign = r_misalign;
    assign bus.st_bad_addr = r_bad_addr;
    assign bus.mem_wvalid  = w_valid;
    assign bus.mem_waddr   = w_valid ? r_addr[r_rd_ptr] : '0;
    assign bus.mem_wdata   = w_valid ? r_data[r_rd_ptr] : 32'h0;
    assign bus.mem_wbe     = w_valid ? r_be[r_rd_ptr]   : 4'b0000;
    assign bus.count       = r_count;
    assign bus.empty       = (r_count == '0);
endmodule
`default_nettype wire

// File: tb/tb_store_lane_buffer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_store_lane_buffer
//  Brief   : Directed scoreboard bench for store_lane_buffer.
//  Revision: 1.0
// ============================================================================
module tb_store_lane_buffer;
    localparam int         c_AW    = 32;
    localparam int         c_DEPTH = 2;
    localparam logic [1:0] c_SB    = 2'b00;
    localparam logic [1:0] c_SH    = 2'b01;
    localparam logic [1:0] c_SW    = 2'b10;
    localparam logic [1:0] c_BAD   = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    wr_t         exp_q[$];
    logic [31:0] rej_q[$];

    store_lane_buffer_if #(.AW(c_AW), .DEPTH(c_DEPTH)) bus ();

    store_lane_buffer #(.AW(c_AW), .DEPTH(c_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Write-port monitor: every handshake must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bus.mem_wvalid && bus.mem_wready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h required=none", bus.mem_waddr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", bus.mem_waddr, e.addr);
                chk("wr_data", bus.mem_wdata, e.data);
                chk("wr_be",   {28'h0, bus.mem_wbe}, {28'h0, e.be});
            end
        end
    end

    // Reject monitor: one pulse per rejected request, carrying its address.
    always @(negedge clk) begin
        if (!rst && bus.st_misalign) begin
            if (rej_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_misalign actual=%h required=none", bus.st_bad_addr);
            end else begin
                chk("bad_addr", bus.st_bad_addr, rej_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                              input logic ok, input logic [31:0] ea, input logic [31:0] ed,
                              input logic [3:0] ebe);
        int waited;
        wr_t e;
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_size  = sz;
        waited = 0;
        @(negedge clk);
        while (!bus.st_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.st_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%h required=accepted", a);
        end else if (ok) begin
            e.addr = ea;
            e.data = ed;
            e.be   = ebe;
            exp_q.push_back(e);
        end else begin
            rej_q.push_back(a);
        end
        @(posedge clk);
        #1;
        bus.st_valid = 1'b0;
    endtask

    logic [31:0] s_addr [10] = '{32'h100, 32'h105, 32'h10A, 32'h10C, 32'h110,
                                 32'h116, 32'h118, 32'h11F, 32'h122, 32'h124};
    logic [31:0] s_data [10] = '{32'h11111111, 32'h000000A1, 32'h0000B2C3, 32'h0000D4E5,
                                 32'hFFFFFF06, 32'h00000017, 32'h89ABCDEF, 32'h00000028,
                                 32'hFFFF3948, 32'hCAFEF00D};
    logic [1:0]  s_size [10] = '{c_SW, c_SB, c_SH, c_SH, c_SB, c_SB, c_SW, c_SB, c_SH, c_SW};
    logic [31:0] s_waddr[10] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
                                 32'h114, 32'h118, 32'h11C, 32'h120, 32'h124};
    logic [31:0] s_wdata[10] = '{32'h11111111, 32'hA1A1A1A1, 32'hB2C3B2C3, 32'hD4E5D4E5,
                                 32'h06060606, 32'h17171717, 32'h89ABCDEF, 32'h28282828,
                                 32'h39483948, 32'hCAFEF00D};
    logic [3:0]  s_wbe  [10] = '{4'b1111, 4'b0010, 4'b1100, 4'b0011, 4'b0001,
                                 4'b0100, 4'b1111, 4'b1000, 4'b1100, 4'b1111};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t e;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.st_valid   = 1'b0;
        bus.st_addr    = '0;
        bus.st_data    = '0;
        bus.st_size    = '0;
        bus.mem_wready = 1'b0;

        @(negedge clk);
        chk("rst_count",    {30'h0, bus.count}, 32'h0);
        chk("rst_empty",    {31'h0, bus.empty}, 32'h1);
        chk("rst_ready",    {31'h0, bus.st_ready}, 32'h1);
        chk("rst_wvalid",   {31'h0, bus.mem_wvalid}, 32'h0);
        chk("rst_waddr",    bus.mem_waddr, 32'h0);
        chk("rst_wdata",    bus.mem_wdata, 32'h0);
        chk("rst_wbe",      {28'h0, bus.mem_wbe}, 32'h0);
        chk("rst_misalign", {31'h0, bus.st_misalign}, 32'h0);
        chk("rst_bad_addr", bus.st_bad_addr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset while two entries wait on a stalled memory
        push_store(32'h5000, 32'h01020304, c_SW, 1'b1, 32'h5000, 32'h01020304, 4'b1111);
        push_store(32'h5004, 32'h05060708, c_SW, 1'b1, 32'h5004, 32'h05060708, 4'b1111);
        chk("pre_rst_count", {30'h0, bus.count}, 32'h2);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_count",  {30'h0, bus.count}, 32'h0);
        chk("mid_rst_wvalid", {31'h0, bus.mem_wvalid}, 32'h0);
        chk("mid_rst_ready",  {31'h0, bus.st_ready}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        bus.mem_wready = 1'b1;
        idle(3);
        chk("post_rst_wvalid", {31'h0, bus.mem_wvalid}, 32'h0);

        // Lane placement
        push_store(32'h1003, 32'hAABBCC5A, c_SB, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'b1000);
        push_store(32'h2002, 32'h1234BEEF, c_SH, 1'b1, 32'h2000, 32'hBEEFBEEF, 4'b1100);
        push_store(32'h2004, 32'hDEADBEEF, c_SW, 1'b1, 32'h2004, 32'hDEADBEEF, 4'b1111);
        idle(3);

        // Rejected stores
        push_store(32'h3002, 32'h0, c_SW, 1'b0, 32'h0, 32'h0, 4'b0000);
        chk("rej_count", {30'h0, bus.count}, 32'h0);
        idle(1);
        push_store(32'h3000, 32'h0, c_BAD, 1'b0, 32'h0, 32'h0, 4'b0000);
        chk("rej_count2", {30'h0, bus.count}, 32'h0);
        idle(1);
        push_store(32'h3001, 32'h0, c_SH, 1'b0, 32'h0, 32'h0, 4'b0000);
        idle(3);
        chk("rej_pulse_end", {31'h0, bus.st_misalign}, 32'h0);

        // Full buffer with stalled memory
        bus.mem_wready = 1'b0;
        push_store(32'h4000, 32'hA0A0A0A0, c_SW, 1'b1, 32'h4000, 32'hA0A0A0A0, 4'b1111);
        push_store(32'h4004, 32'hB0B0B0B0, c_SW, 1'b1, 32'h4004, 32'hB0B0B0B0, 4'b1111);
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h4008;
        bus.st_data  = 32'hC0C0C0C0;
        bus.st_size  = c_SW;
        repeat (2) begin
            @(negedge clk);
            chk("full_ready", {31'h0, bus.st_ready}, 32'h0);
            chk("full_count", {30'h0, bus.count}, 32'h2);
            chk("head_addr",  bus.mem_waddr, 32'h4000);
            chk("head_data",  bus.mem_wdata, 32'hA0A0A0A0);
        end
        @(posedge clk);
        #1 bus.mem_wready = 1'b1;
        @(negedge clk);
        chk("full_ready_same_cycle", {31'h0, bus.st_ready}, 32'h0);
        @(posedge clk);
        #1 bus.mem_wready = 1'b0;
        @(negedge clk);
        chk("ready_after_pop", {31'h0, bus.st_ready}, 32'h1);
        chk("count_after_pop", {30'h0, bus.count}, 32'h1);
        e.addr = 32'h4008;
        e.data = 32'hC0C0C0C0;
        e.be   = 4'b1111;
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.st_valid = 1'b0;
        chk("count_refill", {30'h0, bus.count}, 32'h2);
        bus.mem_wready = 1'b1;
        idle(4);
        chk("drain_count", {30'h0, bus.count}, 32'h0);

        // Continuous streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin
            push_store(s_addr[i], s_data[i], s_size[i], 1'b1, s_waddr[i], s_wdata[i], s_wbe[i]);
            chk("stream_count_le1", {31'h0, (bus.count <= 1)}, 32'h1);
        end
        idle(4);
        chk("stream_empty", {31'h0, bus.empty}, 32'h1);

        chk("sb_drained",  exp_q.size(), 32'h0);
        chk("rej_drained", rej_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
